axi4_lite_interconnect_1xn: RTL and testbench

AXI4_LITE_INTERCONNECT_1XN -- requirements
Module: axi4_lite_interconnect_1xn

---
 rtl/axi4_lite_interconnect_1xn_pkg.sv | 19 +
 rtl/axi4_lite_interconnect_1xn_if.sv | 51 +++++
 rtl/axi4_lite_interconnect_1xn_addr_decoder.sv | 26 ++
 rtl/axi4_lite_interconnect_1xn.sv | 199 +++++++++++++++++++
 tb/tb_axi4_lite_interconnect_1xn.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_interconnect_1xn_pkg.sv
// Shared address map, default widths and response codes for the 1xN AXI4-Lite interconnect.
package axi4_lite_interconnect_1xn_pkg;

  localparam int AXI_SLAVE_NUM  = 2;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  // Each slave owns one 256-byte window; an address matching no window is unmapped
  localparam logic [AXI_ADDR_WIDTH-1:0] SLAVE_BASE_ADDR [AXI_SLAVE_NUM] = '{32'h0000_0000, 32'h0000_0100};
  localparam logic [AXI_ADDR_WIDTH-1:0] SLAVE_ADDR_MASK [AXI_SLAVE_NUM] = '{32'hFFFF_FF00, 32'hFFFF_FF00};

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

endpackage

// File: rtl/axi4_lite_interconnect_1xn_if.sv
// Bus bundle for the 1xN interconnect: upstream s_* channels and per-slave packed m_* channels.
interface axi4_lite_interconnect_1xn_if
  import axi4_lite_interconnect_1xn_pkg::*;
#(
  parameter int SLAVE_NUM  = AXI_SLAVE_NUM,
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0]   s_awaddr;
  logic                    s_awvalid, s_awready;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;
  logic                    s_wvalid, s_wready;
  logic [1:0]              s_bresp;
  logic                    s_bvalid, s_bready;
  logic [ADDR_WIDTH-1:0]   s_araddr;
  logic                    s_arvalid, s_arready;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rvalid, s_rready;

  logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0]   m_awaddr;
  logic [SLAVE_NUM-1:0]                   m_awvalid, m_awready;
  logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0]   m_wdata;
  logic [SLAVE_NUM-1:0][DATA_WIDTH/8-1:0] m_wstrb;
  logic [SLAVE_NUM-1:0]                   m_wvalid, m_wready;
  logic [SLAVE_NUM-1:0][1:0]              m_bresp;
  logic [SLAVE_NUM-1:0]                   m_bvalid, m_bready;
  logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0]   m_araddr;
  logic [SLAVE_NUM-1:0]                   m_arvalid, m_arready;
  logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0]   m_rdata;
  logic [SLAVE_NUM-1:0][1:0]              m_rresp;
  logic [SLAVE_NUM-1:0]                   m_rvalid, m_rready;

  // The interconnect is the slave of the upstream master and the master of every downstream port
  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
  );

endinterface

// File: rtl/axi4_lite_interconnect_1xn_addr_decoder.sv
// Combinational address decoder: one-hot slave select plus a hit flag, lowest index wins on overlap.
module axi4_lite_addr_decoder
  import axi4_lite_interconnect_1xn_pkg::*;
#(
  parameter int SLAVE_NUM  = AXI_SLAVE_NUM,
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SLAVE_NUM-1:0]  sel,
  output logic                  hit
);

  // Scanning from the top down lets the lowest matching index overwrite any higher one
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if ((addr & ADDR_WIDTH'(SLAVE_ADDR_MASK[i])) == ADDR_WIDTH'(SLAVE_BASE_ADDR[i])) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_interconnect_1xn.sv
// 1xN AXI4-Lite interconnect with independent single-outstanding write and read FSMs.
// Define AXI_DECERR_EN to answer unmapped addresses with DECERR instead of routing them to slave 0.
module axi4_lite_interconnect_1xn
  import axi4_lite_interconnect_1xn_pkg::*;
#(
  parameter int SLAVE_NUM  = AXI_SLAVE_NUM,
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH
) (
  input logic                          clk,
  input logic                          rst_n,
  axi4_lite_interconnect_1xn_if.slave  bus
);

`ifdef AXI_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  localparam logic [1:0] W_IDLE = 2'd0, W_FWD = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_FWD = 2'd1, R_RESP = 2'd2;

  logic                    alive;
  logic [1:0]              w_state, r_state;
  logic                    aw_held, w_held, aw_done, wd_done, w_err, b_valid;
  logic [1:0]              b_resp;
  logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0]   w_data, r_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [SLAVE_NUM-1:0]    w_sel, r_sel, aw_dec_sel, ar_dec_sel;
  logic                    aw_dec_hit, ar_dec_hit, r_err, r_valid;
  logic [1:0]              r_resp;
  logic                    sel_awready, sel_wready, sel_bvalid, sel_arready, sel_rvalid;
  logic [1:0]              sel_bresp, sel_rresp;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    fwd_write;

  axi4_lite_addr_decoder #(.SLAVE_NUM(SLAVE_NUM), .ADDR_WIDTH(ADDR_WIDTH)) u_aw_dec (
    .addr(bus.s_awaddr), .sel(aw_dec_sel), .hit(aw_dec_hit)
  );

  axi4_lite_addr_decoder #(.SLAVE_NUM(SLAVE_NUM), .ADDR_WIDTH(ADDR_WIDTH)) u_ar_dec (
    .addr(bus.s_araddr), .sel(ar_dec_sel), .hit(ar_dec_hit)
  );

  // Keeps the upstream readies low during reset and for the edge that releases it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  assign bus.s_awready = alive && (w_state == W_IDLE) && !aw_held;
  assign bus.s_wready  = alive && (w_state == W_IDLE) && !w_held;
  assign bus.s_arready = alive && (r_state == R_IDLE);
  assign bus.s_bvalid  = b_valid;
  assign bus.s_bresp   = b_resp;
  assign bus.s_rvalid  = r_valid;
  assign bus.s_rresp   = r_resp;
  assign bus.s_rdata   = r_data;

  assign fwd_write     = (w_state == W_FWD) && !w_err;
  assign bus.m_awvalid = (fwd_write && !aw_done) ? w_sel : '0;
  assign bus.m_wvalid  = (fwd_write && !wd_done) ? w_sel : '0;
  assign bus.m_bready  = ((w_state == W_RESP) && !w_err && !b_valid) ? w_sel : '0;
  assign bus.m_arvalid = ((r_state == R_FWD) && !r_err) ? r_sel : '0;
  assign bus.m_rready  = ((r_state == R_RESP) && !r_err && !r_valid) ? r_sel : '0;
  assign bus.m_awaddr  = {SLAVE_NUM{aw_addr}};
  assign bus.m_wdata   = {SLAVE_NUM{w_data}};
  assign bus.m_wstrb   = {SLAVE_NUM{w_strb}};
  assign bus.m_araddr  = {SLAVE_NUM{ar_addr}};

  always_comb begin
    sel_awready = |(bus.m_awready & w_sel);
    sel_wready  = |(bus.m_wready  & w_sel);
    sel_bvalid  = |(bus.m_bvalid  & w_sel);
    sel_arready = |(bus.m_arready & r_sel);
    sel_rvalid  = |(bus.m_rvalid  & r_sel);
    sel_bresp   = '0;
    sel_rresp   = '0;
    sel_rdata   = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (w_sel[i]) sel_bresp = bus.m_bresp[i];
      if (r_sel[i]) begin
        sel_rresp = bus.m_rresp[i];
        sel_rdata = bus.m_rdata[i];
      end
    end
  end

  // Unmapped addresses fall back to slave 0; w_err/r_err mark them when DECERR answering is built in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_done <= 1'b0;
      wd_done <= 1'b0;
      w_err   <= 1'b0;
      w_sel   <= '0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      b_valid <= 1'b0;
      b_resp  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (bus.s_awvalid && bus.s_awready) begin
            aw_addr <= bus.s_awaddr;
            w_sel   <= aw_dec_hit ? aw_dec_sel : SLAVE_NUM'(1);
            w_err   <= DECERR_EN && !aw_dec_hit;
            aw_held <= 1'b1;
          end
          if (bus.s_wvalid && bus.s_wready) begin
            w_data <= bus.s_wdata;
            w_strb <= bus.s_wstrb;
            w_held <= 1'b1;
          end
          if (aw_held && w_held) begin
            aw_done <= 1'b0;
            wd_done <= 1'b0;
            w_state <= W_FWD;
          end
        end
        W_FWD: begin
          if (w_err) begin
            b_valid <= 1'b1;
            b_resp  <= DECERR;
            w_state <= W_RESP;
          end else begin
            aw_done <= aw_done || sel_awready;
            wd_done <= wd_done || sel_wready;
            if ((aw_done || sel_awready) && (wd_done || sel_wready)) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (!b_valid && !w_err && sel_bvalid) begin
            b_valid <= 1'b1;
            b_resp  <= sel_bresp;
          end
          if (b_valid && bus.s_bready) begin
            b_valid <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      ar_addr <= '0;
      r_sel   <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_resp  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bus.s_arvalid && bus.s_arready) begin
            ar_addr <= bus.s_araddr;
            r_sel   <= ar_dec_hit ? ar_dec_sel : SLAVE_NUM'(1);
            r_err   <= DECERR_EN && !ar_dec_hit;
            r_state <= R_FWD;
          end
        end
        R_FWD: begin
          if (r_err) begin
            r_valid <= 1'b1;
            r_resp  <= DECERR;
            r_data  <= '0;
            r_state <= R_RESP;
          end else if (sel_arready) begin
            r_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (!r_valid && !r_err && sel_rvalid) begin
            r_valid <= 1'b1;
            r_resp  <= sel_rresp;
            r_data  <= sel_rdata;
          end
          if (r_valid && bus.s_rready) begin
            r_valid <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_interconnect_1xn.sv
// Self-checking bench for axi4_lite_interconnect_1xn: random-latency slave models plus a flat memory reference.
module tb_axi4_lite_interconnect_1xn;
  import axi4_lite_interconnect_1xn_pkg::*;

  localparam int NS = AXI_SLAVE_NUM;
`ifdef AXI_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axi4_lite_interconnect_1xn_if bus ();

  axi4_lite_interconnect_1xn dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Downstream slave models with random handshake and response latencies
  logic [NS-1:0]        sl_awready, sl_wready, sl_bvalid, sl_arready, sl_rvalid;
  logic [NS-1:0]        aw_got, w_got, ar_got;
  logic [NS-1:0][1:0]   sl_bresp, sl_rresp;
  logic [NS-1:0][31:0]  sl_rdata, aw_a, w_d, ar_a;
  logic [NS-1:0][3:0]   w_s;
  logic [31:0]          sl_mem [NS][64] = '{default: '0};
  int                   wr_cnt [NS] = '{default: 0};
  int                   rd_cnt [NS] = '{default: 0};
  int                   mvalid_cycles = 0;

  logic [31:0]          mdl_mem [NS][64] = '{default: '0};

  assign bus.m_awready = sl_awready;
  assign bus.m_wready  = sl_wready;
  assign bus.m_bvalid  = sl_bvalid;
  assign bus.m_bresp   = sl_bresp;
  assign bus.m_arready = sl_arready;
  assign bus.m_rvalid  = sl_rvalid;
  assign bus.m_rresp   = sl_rresp;
  assign bus.m_rdata   = sl_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_awready <= '0; sl_wready <= '0; sl_bvalid <= '0; sl_arready <= '0; sl_rvalid <= '0;
      aw_got <= '0; w_got <= '0; ar_got <= '0;
      sl_bresp <= '0; sl_rresp <= '0; sl_rdata <= '0;
    end else begin
      for (int g = 0; g < NS; g++) begin
        if (bus.m_awvalid[g] && sl_awready[g]) begin
          aw_got[g] <= 1'b1; aw_a[g] <= bus.m_awaddr[g]; sl_awready[g] <= 1'b0;
        end else if (!aw_got[g]) sl_awready[g] <= 1'($urandom_range(0, 1));
        if (bus.m_wvalid[g] && sl_wready[g]) begin
          w_got[g] <= 1'b1; w_d[g] <= bus.m_wdata[g]; w_s[g] <= bus.m_wstrb[g]; sl_wready[g] <= 1'b0;
        end else if (!w_got[g]) sl_wready[g] <= 1'($urandom_range(0, 1));
        if (aw_got[g] && w_got[g] && !sl_bvalid[g] && ($urandom_range(0, 2) == 0)) begin
          for (int b = 0; b < 4; b++)
            if (w_s[g][b]) sl_mem[g][aw_a[g][7:2]][8*b +: 8] <= w_d[g][8*b +: 8];
          sl_bvalid[g] <= 1'b1;
          sl_bresp[g]  <= (aw_a[g][7:2] == 6'h3F) ? 2'b10 : 2'b00;
          wr_cnt[g]    <= wr_cnt[g] + 1;
        end
        if (sl_bvalid[g] && bus.m_bready[g]) begin
          sl_bvalid[g] <= 1'b0; aw_got[g] <= 1'b0; w_got[g] <= 1'b0;
        end
        if (bus.m_arvalid[g] && sl_arready[g]) begin
          ar_got[g] <= 1'b1; ar_a[g] <= bus.m_araddr[g]; sl_arready[g] <= 1'b0;
        end else if (!ar_got[g]) sl_arready[g] <= 1'($urandom_range(0, 1));
        if (ar_got[g] && !sl_rvalid[g] && ($urandom_range(0, 2) == 0)) begin
          sl_rvalid[g] <= 1'b1;
          sl_rdata[g]  <= sl_mem[g][ar_a[g][7:2]];
          sl_rresp[g]  <= (ar_a[g][7:2] == 6'h3F) ? 2'b10 : 2'b00;
          rd_cnt[g]    <= rd_cnt[g] + 1;
        end
        if (sl_rvalid[g] && bus.m_rready[g]) begin
          sl_rvalid[g] <= 1'b0; ar_got[g] <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk)
    if ((|bus.m_awvalid) || (|bus.m_wvalid) || (|bus.m_arvalid)) mvalid_cycles <= mvalid_cycles + 1;

  // Reference address map: 0x000-0x0FF slave 0, 0x100-0x1FF slave 1, anything else unmapped (-1)
  function automatic int target(input logic [31:0] a);
    int r;
    if (a < 32'h100)      r = 0;
    else if (a < 32'h200) r = 1;
    else                  r = DECERR_EN ? -1 : 0;
    return r;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (target(a) < 0) return 2'b11;
    return (a[7:2] == 6'h3F) ? 2'b10 : 2'b00;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lead > 0: W leads AW by that many cycles; lead < 0: AW leads W
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input bit hold_b, output logic [1:0] resp, output bit timed_out);
    int cyc;
    int aw_start, w_start;
    bit aw_pend, w_pend, aw_f, w_f, b_done;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    aw_pend = 1'b1; w_pend = 1'b1; b_done = 1'b0; cyc = 0; resp = 2'b00;
    bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = strb;
    bus.s_awvalid = (aw_start == 0); bus.s_wvalid = (w_start == 0);
    while ((aw_pend || w_pend) && cyc < 200) begin
      @(negedge clk);
      aw_f = bus.s_awvalid && bus.s_awready;
      w_f  = bus.s_wvalid && bus.s_wready;
      @(posedge clk); #1; cyc++;
      if (aw_f) begin aw_pend = 1'b0; bus.s_awvalid = 1'b0; end
      if (w_f)  begin w_pend  = 1'b0; bus.s_wvalid  = 1'b0; end
      if (aw_pend && cyc >= aw_start) bus.s_awvalid = 1'b1;
      if (w_pend && cyc >= w_start)   bus.s_wvalid  = 1'b1;
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    while (!b_done && cyc < 400) begin
      bus.s_bready = hold_b ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.s_bvalid && (hold_b || bus.s_bready)) begin resp = bus.s_bresp; b_done = 1'b1; end
      @(posedge clk); #1; cyc++;
    end
    bus.s_bready = 1'b0;
    timed_out = !b_done;
  endtask

  task automatic read_txn(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output bit timed_out);
    int cyc;
    bit pend, f, done;
    pend = 1'b1; done = 1'b0; cyc = 0; data = '0; resp = 2'b00;
    bus.s_araddr = addr; bus.s_arvalid = 1'b1;
    while (pend && cyc < 200) begin
      @(negedge clk);
      f = bus.s_arvalid && bus.s_arready;
      @(posedge clk); #1; cyc++;
      if (f) begin pend = 1'b0; bus.s_arvalid = 1'b0; end
    end
    bus.s_arvalid = 1'b0;
    while (!done && cyc < 400) begin
      bus.s_rready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.s_rvalid && bus.s_rready) begin data = bus.s_rdata; resp = bus.s_rresp; done = 1'b1; end
      @(posedge clk); #1; cyc++;
    end
    bus.s_rready = 1'b0;
    timed_out = !done;
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int lead, input bit hold_b);
    int t, c0, c1, mv;
    logic [1:0] resp;
    bit to;
    t = target(addr); c0 = wr_cnt[0]; c1 = wr_cnt[1]; mv = mvalid_cycles;
    write_txn(addr, data, strb, lead, hold_b, resp, to);
    checkOutput({tag, "_timeout"}, 64'(to), 64'(0));
    checkOutput({tag, "_bresp"}, 64'(resp), 64'(exp_resp(addr)));
    checkOutput({tag, "_s0_writes"}, 64'(wr_cnt[0] - c0), 64'(t == 0));
    checkOutput({tag, "_s1_writes"}, 64'(wr_cnt[1] - c1), 64'(t == 1));
    checkOutput({tag, "_no_fwd"}, 64'(mvalid_cycles == mv), 64'(t < 0));
    if (t >= 0)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl_mem[t][addr[7:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input bit check_quiet);
    int t, c0, c1, mv;
    logic [31:0] data, exp_data;
    logic [1:0] resp;
    bit to;
    t = target(addr); c0 = rd_cnt[0]; c1 = rd_cnt[1]; mv = mvalid_cycles;
    exp_data = (t < 0) ? 32'h0 : mdl_mem[(t < 0) ? 0 : t][addr[7:2]];
    read_txn(addr, data, resp, to);
    checkOutput({tag, "_timeout"}, 64'(to), 64'(0));
    checkOutput({tag, "_rdata"}, 64'(data), 64'(exp_data));
    checkOutput({tag, "_rresp"}, 64'(resp), 64'(exp_resp(addr)));
    checkOutput({tag, "_s0_reads"}, 64'(rd_cnt[0] - c0), 64'(t == 0));
    checkOutput({tag, "_s1_reads"}, 64'(rd_cnt[1] - c1), 64'(t == 1));
    if (check_quiet) checkOutput({tag, "_no_fwd"}, 64'(mvalid_cycles == mv), 64'(t < 0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int          c0;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_awready", 64'(bus.s_awready), 64'(0));
    checkOutput("rst_wready", 64'(bus.s_wready), 64'(0));
    checkOutput("rst_arready", 64'(bus.s_arready), 64'(0));
    checkOutput("rst_bvalid", 64'(bus.s_bvalid), 64'(0));
    checkOutput("rst_rvalid", 64'(bus.s_rvalid), 64'(0));
    checkOutput("rst_m_valids", 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 checkOutput("rel_awready_before_edge", 64'(bus.s_awready), 64'(0));
    @(posedge clk); #1;
    checkOutput("rel_awready", 64'(bus.s_awready), 64'(1));
    checkOutput("rel_wready", 64'(bus.s_wready), 64'(1));
    checkOutput("rel_arready", 64'(bus.s_arready), 64'(1));

    applyStimulus("wr_s0_beef", 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    checkOutput("s0_mem_beef", 64'(sl_mem[0][1]), 64'h0000_0000_DEAD_BEEF);

    applyStimulus("wr_s1_setup", 32'h0000_0108, 32'h1234_5678, 4'hF, 0, 1'b0);
    c0 = wr_cnt[0];
    readCheck("rd_s1_108", 32'h0000_0108, 1'b0);
    checkOutput("rd_s1_s0_untouched", 64'(wr_cnt[0] - c0), 64'(0));

    applyStimulus("wr_w_early", 32'h0000_0110, 32'hA5A5_0F0F, 4'hF, 3, 1'b0);
    readCheck("rd_w_early", 32'h0000_0110, 1'b0);
    applyStimulus("wr_aw_early", 32'h0000_0020, 32'h0BAD_F00D, 4'h5, -2, 1'b0);

    applyStimulus("wr_unmapped", 32'h0000_0200, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
    readCheck("rd_unmapped", 32'h0000_0200, 1'b1);

    fork
      applyStimulus("par_wr_s0", 32'h0000_000C, 32'hCAFE_D00D, 4'hF, 1, 1'b0);
      readCheck("par_rd_s1", 32'h0000_0108, 1'b0);
    join
    readCheck("par_rd_back", 32'h0000_000C, 1'b0);

    applyStimulus("wr_hold_b", 32'h0000_0008, 32'h5555_AAAA, 4'hF, 0, 1'b1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_bvalid", 64'(bus.s_bvalid), 64'(0));
    checkOutput("midrst_awready", 64'(bus.s_awready), 64'(0));
    checkOutput("midrst_arready", 64'(bus.s_arready), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_rel_awready", 64'(bus.s_awready), 64'(1));
    checkOutput("midrst_bvalid_after", 64'(bus.s_bvalid), 64'(0));
    applyStimulus("wr_after_rst", 32'h0000_0018, 32'h0102_0304, 4'hF, 0, 1'b0);
    readCheck("rd_after_rst", 32'h0000_0018, 1'b0);
    readCheck("rd_held_write", 32'h0000_0008, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 2)) * 32'h100 + 32'($urandom_range(0, 63)) * 32'h4;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      applyStimulus($sformatf("rnd%0d_wr", n), a, d, s, int'($urandom_range(0, 6)) - 3, 1'b0);
      readCheck($sformatf("rnd%0d_rd", n), a, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
